// File: rtl/branch_next_pc_unit_if.sv
// Execute-to-fetch bundle for the branch/next-PC unit: operands, targets and type code in,
// branch decision, next PC and current PC out.
interface branch_next_pc_unit_if #(
  parameter int XLEN = 32
) ();
  logic            en;
  logic [3:0]      info_branch;
  logic [XLEN-1:0] reg1;
  logic [XLEN-1:0] reg2;
  logic [XLEN-1:0] branch;
  logic [XLEN-1:0] notbranch;
  logic            branch_signal;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc;

  modport master (
    output en, info_branch, reg1, reg2, branch, notbranch,
    input  branch_signal, npc, pc
  );

  modport slave (
    input  en, info_branch, reg1, reg2, branch, notbranch,
    output branch_signal, npc, pc
  );
endinterface

// File: rtl/branch_next_pc_unit.sv
// Resolves RISC-V conditional branches and jumps, selects the next PC, and holds the
// architectural PC register.
module branch_next_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   rst,
  branch_next_pc_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    NOTBRANCH = 4'd0,
    BEQ       = 4'd1,
    BNE       = 4'd2,
    BLT       = 4'd3,
    BGE       = 4'd4,
    BLTU      = 4'd5,
    BGEU      = 4'd6,
    BJAL      = 4'd7,
    BJALR     = 4'd8
  } branchType_e;

  logic            branchTaken;
  logic [XLEN-1:0] nextPc;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Reserved codes fall into the default arm so they behave exactly like NOTBRANCH.
  always_comb begin
    branchTaken = 1'b0;
    case (branchType_e'(bus.info_branch))
      BEQ:     branchTaken = (bus.reg1 == bus.reg2);
      BNE:     branchTaken = (bus.reg1 != bus.reg2);
      BLT:     branchTaken = ($signed(bus.reg1) <  $signed(bus.reg2));
      BGE:     branchTaken = ($signed(bus.reg1) >= $signed(bus.reg2));
      BLTU:    branchTaken = (bus.reg1 <  bus.reg2);
      BGEU:    branchTaken = (bus.reg1 >= bus.reg2);
      BJAL:    branchTaken = 1'b1;
      BJALR:   branchTaken = 1'b1;
      default: branchTaken = 1'b0;
    endcase
  end

  // Targets pass through untouched; JALR LSB clearing is left to the target producer.
  always_comb begin
    nextPc = branchTaken ? bus.branch : bus.notbranch;
    pc_d   = bus.en ? nextPc : pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.branch_signal = branchTaken;
  assign bus.npc           = nextPc;
  assign bus.pc            = pc_q;

endmodule

// File: tb/tb_branch_next_pc_unit.sv
// Directed bench for branch_next_pc_unit: branch decisions, next-PC selection and the
// PC register's reset/enable behaviour, against hand-computed expectations.
module tb_branch_next_pc_unit;

  localparam int XLEN = 32;

  localparam logic [3:0] C_NOTBRANCH = 4'd0;
  localparam logic [3:0] C_BEQ       = 4'd1;
  localparam logic [3:0] C_BNE       = 4'd2;
  localparam logic [3:0] C_BLT       = 4'd3;
  localparam logic [3:0] C_BGE       = 4'd4;
  localparam logic [3:0] C_BLTU      = 4'd5;
  localparam logic [3:0] C_BGEU      = 4'd6;
  localparam logic [3:0] C_BJAL      = 4'd7;
  localparam logic [3:0] C_BJALR     = 4'd8;

  localparam logic [XLEN-1:0] R1  = 32'hFFAB_CD5A;
  localparam logic [XLEN-1:0] R2  = 32'h123A_BDEA;
  localparam logic [XLEN-1:0] BR  = 32'hAABB_CCDD;
  localparam logic [XLEN-1:0] NBR = 32'hDDCC_BBAA;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  branch_next_pc_unit_if #(.XLEN(XLEN)) bus ();

  branch_next_pc_unit #(
    .XLEN    (XLEN),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] code, input logic [XLEN-1:0] r1,
                               input logic [XLEN-1:0] r2, input logic [XLEN-1:0] br,
                               input logic [XLEN-1:0] nbr);
    bus.info_branch = code;
    bus.reg1        = r1;
    bus.reg2        = r2;
    bus.branch      = br;
    bus.notbranch   = nbr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expSig, input logic [XLEN-1:0] expNpc);
    checkCount++;
    assert (bus.branch_signal === expSig) passCount++;
    else $error("[TB] FAIL %s signal: got %0b expected %0b", tag, bus.branch_signal, expSig);
    checkCount++;
    assert (bus.npc === expNpc) passCount++;
    else $error("[TB] FAIL %s npc: got %h expected %h", tag, bus.npc, expNpc);
  endtask

  task automatic checkPc(input string tag, input logic [XLEN-1:0] expPc);
    checkCount++;
    assert (bus.pc === expPc) passCount++;
    else $error("[TB] FAIL %s pc: got %h expected %h", tag, bus.pc, expPc);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    bus.en     = 1'b0;
    applyStimulus(C_NOTBRANCH, '0, '0, '0, '0);
    checkPc("reset", 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;

    $display("[TB] branch conditions, mixed-sign operands");
    applyStimulus(C_BEQ,  R1, R2, BR, NBR); checkOutput("beq",  1'b0, NBR);
    applyStimulus(C_BNE,  R1, R2, BR, NBR); checkOutput("bne",  1'b1, BR);
    applyStimulus(C_BLT,  R1, R2, BR, NBR); checkOutput("blt",  1'b1, BR);
    applyStimulus(C_BGE,  R1, R2, BR, NBR); checkOutput("bge",  1'b0, NBR);
    applyStimulus(C_BLTU, R1, R2, BR, NBR); checkOutput("bltu", 1'b0, NBR);
    applyStimulus(C_BGEU, R1, R2, BR, NBR); checkOutput("bgeu", 1'b1, BR);

    $display("[TB] jumps and non-branch codes");
    applyStimulus(C_BJAL,      R1, R2, BR, NBR); checkOutput("jal",      1'b1, BR);
    applyStimulus(C_BJALR,     R1, R2, BR, NBR); checkOutput("jalr",     1'b1, BR);
    applyStimulus(C_NOTBRANCH, R1, R2, BR, NBR); checkOutput("nobranch", 1'b0, NBR);
    applyStimulus(4'hF,        R1, R2, BR, NBR); checkOutput("reserved", 1'b0, NBR);
    applyStimulus(4'h9,        R1, R1, BR, NBR); checkOutput("reserved9", 1'b0, NBR);
    applyStimulus(C_BJAL, 'x, 'x, BR, NBR);      checkOutput("jal_xops", 1'b1, BR);
    applyStimulus(C_NOTBRANCH, 'x, 'x, BR, NBR); checkOutput("nob_xops", 1'b0, NBR);

    $display("[TB] equal operands at the sign boundary");
    applyStimulus(C_BEQ,  32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_beq",  1'b1, BR);
    applyStimulus(C_BNE,  32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_bne",  1'b0, NBR);
    applyStimulus(C_BLT,  32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_blt",  1'b0, NBR);
    applyStimulus(C_BGE,  32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_bge",  1'b1, BR);
    applyStimulus(C_BLTU, 32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_bltu", 1'b0, NBR);
    applyStimulus(C_BGEU, 32'h8000_0000, 32'h8000_0000, BR, NBR); checkOutput("eq_bgeu", 1'b1, BR);
    applyStimulus(C_BLT,  32'h7FFF_FFFF, 32'h8000_0000, BR, NBR); checkOutput("max_blt",  1'b0, NBR);
    applyStimulus(C_BLTU, 32'h7FFF_FFFF, 32'h8000_0000, BR, NBR); checkOutput("max_bltu", 1'b1, BR);
    applyStimulus(C_BGE,  32'h7FFF_FFFF, 32'h8000_0000, BR, NBR); checkOutput("max_bge",  1'b1, BR);

    $display("[TB] pc register");
    @(posedge clk); #1;
    checkPc("stall_hold0", 32'h0000_0000);

    @(negedge clk);
    bus.en = 1'b1;
    applyStimulus(C_BJAL, '0, '0, 32'h0000_2000, 32'h0000_0004);
    @(posedge clk); #1;
    checkPc("jal_update", 32'h0000_2000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkPc("async_rst", 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(C_BNE, 32'h1, 32'h2, 32'h0000_1000, 32'h0000_0004);
    @(posedge clk); #1;
    checkPc("bne_update", 32'h0000_1000);

    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkPc("en0_hold", 32'h0000_1000);
    end

    @(negedge clk);
    bus.en = 1'b1;
    applyStimulus(C_BEQ, 32'h5, 32'h6, 32'h0000_3000, 32'h0000_1004);
    @(posedge clk); #1;
    checkPc("fallthrough", 32'h0000_1004);

    #2;
    rst = 1'b1;
    #1;
    checkPc("midcycle_rst", 32'h0000_0000);
    applyStimulus(C_BEQ, 32'h7, 32'h7, 32'h0000_4000, 32'h0000_0008);
    checkOutput("comb_in_rst", 1'b1, 32'h0000_4000);
    @(posedge clk); #1;
    checkPc("rst_over_edge", 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkPc("rst_release", 32'h0000_0000);
    @(posedge clk); #1;
    checkPc("first_after_rst", 32'h0000_4000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/branch_next_pc_unit.md
Name: branch_next_pc_unit

Overview:
- Decides whether the current instruction redirects control flow (RISC-V conditional branches, JAL, JALR) and selects the next PC.
- Combines branch-condition evaluation with next-PC selection. Also holds the architectural PC register.
- Sits between the execute stage (register operands, ALU-computed target) and the fetch stage (PC).

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  PC update enable; 0 = stall, PC holds.
- info_branch  input  4  branch type code.
- reg1  input  XLEN  rs1 operand.
- reg2  input  XLEN  rs2 operand.
- branch  input  XLEN  taken target (ALU result).
- notbranch  input  XLEN  fall-through target (PC+4).
- branch_signal  output  1  1 = control transfer taken.
- npc  output  XLEN  selected next PC.
- pc  output  XLEN  registered current PC.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- info_branch encoding:
  - NOTBRANCH=4'd0
  - Beq=1, Bne=2, Blt=3, Bge=4, Bltu=5, Bgeu=6
  - BJAL=7, BJALR=8
  - Codes 9..15 are reserved and behave as NOTBRANCH.
- branch_signal (purely combinational, zero latency):
  - Beq: reg1 == reg2.
  - Bne: reg1 != reg2.
  - Blt: signed reg1 < reg2. Bge: signed reg1 >= reg2.
  - Bltu: unsigned reg1 < reg2. Bgeu: unsigned reg1 >= reg2.
  - BJAL, BJALR: always 1.
  - NOTBRANCH and reserved codes: 0.
- Comparisons use the full XLEN. Signed compare treats bit XLEN-1 as the sign bit. No X-propagation from unused operands: for JAL/JALR/NOTBRANCH, branch_signal is independent of reg1/reg2.
- npc (combinational): branch when branch_signal=1, else notbranch. Passed through unmodified; no alignment masking, including the JALR LSB.
- npc and branch_signal settle in the same evaluation as their inputs, with no clock dependence.
- pc register:
  - While rst=1: pc = RESET_PC immediately, regardless of clk or en.
  - On each rising clk with rst=0 and en=1: pc <= npc.
  - With en=0: pc holds.
  - rst asserted mid-operation overrides any pending update. The first update after rst deasserts occurs on the next rising edge with en=1.
- Combinational outputs do not depend on rst: branch_signal and npc stay valid during reset.
- Equal operands: Bge and Bgeu are taken; Blt and Bltu are not taken.

Test Plan:
- reg1=FFABCD5A, reg2=123ABDEA, branch=AABBCCDD, notbranch=DDCCBBAA:
  - Beq -> signal 0, npc DDCCBBAA.
  - Bne -> signal 1, npc AABBCCDD.
- Same operands:
  - Blt -> 1/AABBCCDD (signed negative < positive).
  - Bge -> 0/DDCCBBAA.
  - Bltu -> 0/DDCCBBAA.
  - Bgeu -> 1/AABBCCDD.
- Same operands:
  - BJAL -> 1/AABBCCDD.
  - BJALR -> 1/AABBCCDD (odd target unmasked).
  - NOTBRANCH -> 0/DDCCBBAA.
  - Code 4'hF -> 0/DDCCBBAA.
- Equal-operand boundaries:
  - reg1=reg2=80000000: Beq 1, Bne 0, Blt 0, Bge 1, Bltu 0, Bgeu 1.
  - reg1=7FFFFFFF, reg2=80000000: Blt 0, Bltu 1.
- PC register sequence:
  - Assert rst between edges -> pc=00000000 at once.
  - Release rst, en=1, Bne taken with branch=00001000 -> pc=00001000 after one edge.
  - en=0 for 3 edges -> pc holds 00001000.
  - Assert rst mid-cycle -> pc=00000000 before the next edge.
